// File: rtl/seq_det_scheduler.sv
// Round-robin shared serial pattern detector: two word requesters take turns feeding one
// overlapping-match detector; each job returns its hit count over a valid/ready channel.
module seq_det_scheduler #(
   parameter int unsigned      WORD_W  = 8,
   parameter int unsigned      PAT_W   = 5,
   parameter int unsigned      CNT_W   = 4,
   parameter logic [PAT_W-1:0] RST_PAT = 5'b11011
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [PAT_W-1:0]  cfg_pattern,
   input  logic              req0_valid,
   input  logic [WORD_W-1:0] req0_word,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [WORD_W-1:0] req1_word,
   output logic              req1_ready,
   output logic              busy,
   output logic              det_bit,
   output logic              det_hit,
   output logic              rsp_valid,
   output logic              rsp_id,
   output logic [CNT_W-1:0]  rsp_count,
   input  logic              rsp_ready
);

   localparam int unsigned IDX_W  = $clog2(WORD_W);
   localparam int unsigned FILL_W = $clog2(PAT_W + 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORD_W - 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

   typedef enum logic [1:0] {StIdle, StShift, StReport} state_e;

   state_e              state_q;
   logic [PAT_W-1:0]    pattern_q;
   logic [PAT_W-1:0]    history_q;
   logic [FILL_W-1:0]   fill_q;
   logic [IDX_W-1:0]    idx_q;
   logic [CNT_W-1:0]    count_q;
   logic                last_grant_q;
   logic [WORD_W-1:0]   word_q;

   logic                grant0, grant1;
   logic [PAT_W-1:0]    history_d;
   logic [FILL_W-1:0]   fill_d;
   logic [CNT_W-1:0]    count_d;
   logic                hit;

   // With both requesters valid, the one not served last time wins.
   always_comb begin
      grant0 = req0_valid & (~req1_valid | last_grant_q);
      grant1 = req1_valid & (~req0_valid | ~last_grant_q);
   end

   assign req0_ready = (state_q == StIdle) & grant0;
   assign req1_ready = (state_q == StIdle) & grant1;
   assign busy       = (state_q != StIdle);
   // word_q shifts left each SHIFT cycle, so its MSB is always the current serial bit.
   assign det_bit    = (state_q == StShift) & word_q[WORD_W-1];

   always_comb begin
      history_d = {history_q[PAT_W-2:0], det_bit};
      fill_d    = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
      hit       = (history_d == pattern_q) && (fill_d == FILL_FULL);
      count_d   = (hit && (count_q != '1)) ? count_q + 1'b1 : count_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         pattern_q    <= RST_PAT;
         history_q    <= '0;
         fill_q       <= '0;
         idx_q        <= '0;
         count_q      <= '0;
         last_grant_q <= 1'b1;
         word_q       <= '0;
         det_hit      <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_id       <= 1'b0;
         rsp_count    <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (cfg_we) pattern_q <= cfg_pattern;
               if (req0_ready || req1_ready) begin
                  word_q       <= req1_ready ? req1_word : req0_word;
                  rsp_id       <= req1_ready;
                  last_grant_q <= req1_ready;
                  history_q    <= '0;
                  fill_q       <= '0;
                  count_q      <= '0;
                  idx_q        <= '0;
                  state_q      <= StShift;
               end
            end
            StShift: begin
               history_q <= history_d;
               fill_q    <= fill_d;
               count_q   <= count_d;
               det_hit   <= hit;
               word_q    <= {word_q[WORD_W-2:0], 1'b0};
               idx_q     <= idx_q + 1'b1;
               if (idx_q == LAST_IDX) begin
                  rsp_valid <= 1'b1;
                  rsp_count <= count_d;
                  state_q   <= StReport;
               end
            end
            StReport: begin
               det_hit <= 1'b0;
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Bench for seq_det_scheduler: arbitration/detector model feeds a response scoreboard;
// a second instance with a 2-bit counter covers saturation.
module tb_seq_det_scheduler;

   localparam logic [4:0] RST_PAT = 5'b11011;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_we;
   logic [4:0] cfg_pattern;
   logic       req0_valid, req1_valid;
   logic [7:0] req0_word, req1_word;
   logic       req0_ready, req1_ready;
   logic       busy, det_bit, det_hit, rsp_valid, rsp_id;
   logic [3:0] rsp_count;
   logic       rsp_ready;

   logic       d2_req0_ready, d2_req1_ready, d2_busy, d2_det_bit, d2_det_hit;
   logic       d2_rsp_valid, d2_rsp_id;
   logic [1:0] d2_rsp_count;

   seq_det_scheduler #(.WORD_W(8), .PAT_W(5), .CNT_W(4), .RST_PAT(RST_PAT)) u_dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .req0_valid(req0_valid), .req0_word(req0_word), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_word(req1_word), .req1_ready(req1_ready),
      .busy(busy), .det_bit(det_bit), .det_hit(det_hit), .rsp_valid(rsp_valid),
      .rsp_id(rsp_id), .rsp_count(rsp_count), .rsp_ready(rsp_ready)
   );

   seq_det_scheduler #(.WORD_W(8), .PAT_W(5), .CNT_W(2), .RST_PAT(RST_PAT)) u_dut_sat (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .req0_valid(req0_valid), .req0_word(req0_word), .req0_ready(d2_req0_ready),
      .req1_valid(req1_valid), .req1_word(req1_word), .req1_ready(d2_req1_ready),
      .busy(d2_busy), .det_bit(d2_det_bit), .det_hit(d2_det_hit), .rsp_valid(d2_rsp_valid),
      .rsp_id(d2_rsp_id), .rsp_count(d2_rsp_count), .rsp_ready(rsp_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      int id;
      int cnt;
      int cnt2;
   } exp_t;

   exp_t       sb[$];
   int         n_vec = 0;
   int         n_miss = 0;
   logic [4:0] m_pat = RST_PAT;
   int         m_last = 1;

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void model(input logic [7:0] w, input logic [4:0] p, output int cnt,
                                 output logic [7:0] hv);
      logic [4:0] hist = '0;
      int fill = 0;
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         hist = {hist[3:0], w[7-k]};
         if (fill < 5) fill++;
         hv[k] = (hist == p) && (fill == 5);
         if (hv[k]) cnt++;
      end
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, ".busy"}, busy, 0);
      check({tag, ".det_bit"}, det_bit, 0);
      check({tag, ".det_hit"}, det_hit, 0);
      check({tag, ".rsp_valid"}, rsp_valid, 0);
      check({tag, ".rsp_id"}, rsp_id, 0);
      check({tag, ".rsp_count"}, rsp_count, 0);
      check({tag, ".sat_rsp_count"}, d2_rsp_count, 0);
      check({tag, ".ready"}, {req0_ready, req1_ready}, 0);
   endtask

   task automatic job(input logic v0, input logic [7:0] w0, input logic v1, input logic [7:0] w1,
                      input logic cfg, input logic [4:0] cfgp, input logic mid_cfg,
                      input int stall, input int abort_k);
      int         g, c;
      logic [7:0] w, hv;
      exp_t       e;
      @(negedge clk);
      req0_valid = v0; req0_word = w0; req1_valid = v1; req1_word = w1;
      cfg_we = cfg; cfg_pattern = cfgp;
      rsp_ready = (stall == 0);
      #1;
      g = (v0 && v1) ? ((m_last == 0) ? 1 : 0) : (v1 ? 1 : 0);
      check("grant.ready0", req0_ready, (g == 0) ? 1 : 0);
      check("grant.ready1", req1_ready, (g == 1) ? 1 : 0);
      if (cfg) m_pat = cfgp;
      w = g ? w1 : w0;
      model(w, m_pat, c, hv);
      e.id = g; e.cnt = (c > 15) ? 15 : c; e.cnt2 = (c > 3) ? 3 : c;
      sb.push_back(e);
      m_last = g;
      @(posedge clk);
      @(negedge clk);
      cfg_we = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (k == abort_k) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
            rst = 1'b0;
            #1;
            check_reset_outputs("abort");
            void'(sb.pop_back());
            m_pat = RST_PAT; m_last = 1;
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check("abort.no_rsp", rsp_valid, 0);
            return;
         end
         check("shift.busy", busy, 1);
         check("shift.det_bit", det_bit, w[7-k]);
         check("shift.rsp_valid", rsp_valid, 0);
         check("shift.no_grant", {req0_ready, req1_ready}, 0);
         if (k > 0) check("shift.det_hit", det_hit, hv[k-1]);
         // Requester-side changes while busy must not leak in.
         req0_word = 8'($urandom); req1_word = 8'($urandom);
         cfg_we = mid_cfg && (k == 2);
         cfg_pattern = 5'b00000;
         @(posedge clk);
         @(negedge clk);
      end
      cfg_we = 1'b0;
      check("rpt.rsp_valid", rsp_valid, 1);
      check("rpt.det_hit", det_hit, hv[7]);
      check("rpt.det_bit", det_bit, 0);
      if (sb.size() == 0) begin
         check("sb.empty", 1, 0);
      end else begin
         e = sb.pop_front();
         check("rpt.rsp_id", rsp_id, e.id);
         check("rpt.rsp_count", rsp_count, e.cnt);
         check("rpt.sat_count", d2_rsp_count, e.cnt2);
      end
      for (int s = 0; s < stall; s++) begin
         @(posedge clk);
         @(negedge clk);
         check("stall.rsp_valid", rsp_valid, 1);
         check("stall.rsp_id", rsp_id, e.id);
         check("stall.rsp_count", rsp_count, e.cnt);
         check("stall.no_grant", {req0_ready, req1_ready}, 0);
         check("stall.det_hit", det_hit, 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("done.rsp_valid", rsp_valid, 0);
      check("done.busy", busy, 0);
      check("done.det_hit", det_hit, 0);
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; rsp_ready = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0; req0_word = '0; req1_word = '0;
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Reset pattern 11011 over 11011011: hits after bits 5 and 8.
      job(1'b1, 8'hDB, 1'b0, 8'h00, 1'b0, 5'b0, 1'b0, 0, -1);
      // Pattern written on the accept edge applies; a write during SHIFT is ignored.
      job(1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 5'b11111, 1'b1, 0, -1);
      // Both valid: alternating grants 0,1,0,1.
      for (int i = 0; i < 4; i++)
         job(1'b1, 8'h1B, 1'b1, 8'hD8, (i == 0), 5'b11011, 1'b0, 0, -1);
      // Four raw hits: 4 on the 4-bit counter, 3 on the 2-bit counter.
      job(1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 5'b00000, 1'b0, 0, -1);
      // Consumer back-pressure in REPORT.
      job(1'b0, 8'h00, 1'b1, 8'hDB, 1'b1, 5'b11011, 1'b0, 5, -1);
      // Reset mid-job at k=3 after switching the pattern; reset must restore 11011.
      job(1'b1, 8'hDB, 1'b0, 8'h00, 1'b1, 5'b00000, 1'b0, 0, 3);
      job(1'b1, 8'hDB, 1'b0, 8'h00, 1'b0, 5'b0, 1'b0, 0, -1);

      check("sb.drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/seq_det_scheduler.md
Name: seq_det_scheduler

Overview:
Shares one programmable serial pattern detector (Moore-style, registered hit output) between two word-level requesters. Round-robin arbitration grants one requester at a time. The granted WORD_W-bit word is serialized MSB-first into the detector, overlapping pattern hits are counted, and the count is returned with the requester id over a valid/ready response channel. The pattern is configurable only while the block is idle.

Parameters:
WORD_W, 8, width of request words and number of serial bits per job
PAT_W, 5, pattern length in bits (2..WORD_W)
CNT_W, 4, width of hit counter (saturating)
RST_PAT, 5'b11011, pattern loaded at reset (PAT_W bits)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
cfg_we  in  1  pattern write strobe, honoured only in IDLE
cfg_pattern  in  PAT_W  new pattern; cfg_pattern[PAT_W-1] is matched against the oldest bit
req0_valid  in  1  requester 0 has a word
req0_word  in  WORD_W  requester 0 word
req0_ready  out  1  requester 0 word accepted this cycle when valid&ready
req1_valid  in  1  requester 1 has a word
req1_word  in  WORD_W  requester 1 word
req1_ready  out  1  requester 1 accept
busy  out  1  high in SHIFT and REPORT
det_bit  out  1  serial bit currently fed to detector (0 outside SHIFT)
det_hit  out  1  registered detector match flag
rsp_valid  out  1  result available
rsp_id  out  1  requester id of the result
rsp_count  out  CNT_W  number of hits in the word
rsp_ready  in  1  result consumer accepts

Behaviour:
- Reset (rst=0, async) values: state=IDLE, pattern=RST_PAT, history=0, fill=0, bit index=0, count=0, last_grant=1 (req0 wins first), busy=0, det_bit=0, det_hit=0, rsp_valid=0, rsp_id=0, rsp_count=0. Reset mid-job aborts the job silently; no response is produced.
- FSM states: IDLE, SHIFT, REPORT.
- IDLE:
  - Grant is combinational. If exactly one requester is valid, it is granted. If both are valid, the requester != last_grant is granted.
  - reqN_ready = (state==IDLE) & granted N. Only one ready is high at a time.
  - On accept: latch the word, set rsp_id=N, last_grant=N, clear history, fill and count, then go to SHIFT.
  - cfg_we in IDLE loads the pattern at the edge. If it coincides with an accept, the new pattern applies to that word. cfg_we in SHIFT or REPORT is ignored.
- SHIFT: runs for exactly WORD_W cycles, k=0..WORD_W-1.
  - det_bit = word[WORD_W-1-k].
  - Each edge: history={history[PAT_W-2:0],det_bit}; fill=min(fill+1,PAT_W).
  - Hit condition: new history==pattern and new fill==PAT_W. On a hit, det_hit=1 in the next cycle (0 otherwise) and count increments, saturating at 2^CNT_W-1.
  - Matches overlap; history is never cleared by a hit.
  - After the edge consuming bit k=WORD_W-1, go to REPORT.
- REPORT:
  - rsp_valid=1, rsp_count=final count, including any hit on the last bit.
  - rsp_id, rsp_count and rsp_valid hold stable while rsp_ready=0. No request is accepted.
  - On rsp_valid&rsp_ready: rsp_valid=0 at the edge, then IDLE. A new request can be accepted in the following cycle.
  - det_hit clears to 0 on the first REPORT edge.
- Latency: the accept edge is E0. The last bit is consumed at edge E_WORD_W, so rsp_valid is high after edge E_WORD_W (cycle WORD_W+1 relative to accept). Minimum turnaround is WORD_W+2 cycles per job with rsp_ready tied high.
- Request inputs are sampled only at the accept edge. Requester-side changes during SHIFT or REPORT have no effect.

Test Plan:
- Reset RST_PAT=11011; req0 word 8'b11011011, rsp_ready=1 -> det_hit pulses after bits 5 and 8. Response arrives 8 edges after accept with rsp_id=0, rsp_count=2.
- cfg_we=1, cfg_pattern=11111 in IDLE, then req1 word 8'hFF -> rsp_id=1, rsp_count=4. cfg_we=1, cfg_pattern=00000 during SHIFT -> ignored, count still 4.
- req0 and req1 both held valid with words 8'h1B and 8'hD8 -> grants in order 0,1,0,1. Exactly one reqN_ready per accept, no grant while busy.
- CNT_W=2, pattern 00000, word 8'h00 -> raw 4 hits saturate to rsp_count=3.
- rsp_ready=0 for 5 cycles in REPORT -> rsp_valid, rsp_id and rsp_count stable, req ready low. rsp_ready=1 -> IDLE next cycle, next accept follows.
- rst=0 asserted at SHIFT k=3 -> all outputs immediately at reset values, pattern=11011. After release, a fresh req0 word 8'b11011011 returns count 2.
